mips_mc_control: RTL and testbench

Multi-cycle control sequencer for the MIPS32 core. Replaces the single-cycle combinational decoder with a registered state machine that steps the shared datapath through fetch, decode, execute, memory and write-back phases. The sequencer drives every datapath mux select and write strobe. It also accepts a ready handshake from the unified instruction/data memory so that slow memory can stall the core.

---
 rtl/mips_mc_control.sv | 235 +++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle control sequencer for the MIPS32 core.
// Steps the shared datapath through fetch, decode, execute, memory and
// write-back phases. All datapath selects and strobes are decoded from the
// current state, plus mem_ready in the memory states, so an asynchronous
// reset drops every strobe immediately.
// Build option: define MC_CTRL_STALL_EN to honour the mem_ready handshake.
// When it is left undefined, mem_ready is treated as always high and each
// memory state lasts exactly one cycle.
module mips_mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    BOOT     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12,
    HALT     = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_r;
  state_t next_state_s;
  logic   is_store_r;
  logic   ready_s;

`ifdef MC_CTRL_STALL_EN
  assign ready_s = mem_ready;
`else
  // The port is kept so both builds share one interface. Its value is not used.
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign ready_s = 1'b1;
`endif

  // zero_flag gates the PC in the datapath, so the sequencer only exports pc_write_cond.
  logic unused_zero_flag_s;
  assign unused_zero_flag_s = zero_flag;

  assign state_dbg = state_r;

  // State register. Reset returns the sequencer to BOOT asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // lw and sw share MEM_ADDR, so this flop records which one DECODE saw.
  // opcode is ignored in every other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_store_r <= 1'b0;
    end else if (state_r == DECODE) begin
      is_store_r <= (opcode == OP_SW);
    end else begin
      is_store_r <= is_store_r;
    end
  end

  // Next-state logic. The unused encodings 14 and 15 fall back to FETCH.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      BOOT:     next_state_s = FETCH;
      FETCH: begin
        if (ready_s) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = MEM_ADDR;
          OP_RTYPE:     next_state_s = EXEC;
          OP_BEQ:       next_state_s = BRANCH;
          OP_J:         next_state_s = JUMP;
          OP_ADDI:      next_state_s = ADDI_EX;
          default:      next_state_s = HALT;
        endcase
      end
      MEM_ADDR: begin
        if (is_store_r) begin
          next_state_s = MEM_WR;
        end else begin
          next_state_s = MEM_RD;
        end
      end
      MEM_RD: begin
        if (ready_s) begin
          next_state_s = MEM_WB;
        end else begin
          next_state_s = MEM_RD;
        end
      end
      MEM_WR: begin
        if (ready_s) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEM_WR;
        end
      end
      EXEC:     next_state_s = R_WB;
      ADDI_EX:  next_state_s = ADDI_WB;
      MEM_WB:   next_state_s = FETCH;
      R_WB:     next_state_s = FETCH;
      ADDI_WB:  next_state_s = FETCH;
      BRANCH:   next_state_s = FETCH;
      JUMP:     next_state_s = FETCH;
      HALT:     next_state_s = HALT;
      default:  next_state_s = FETCH;
    endcase
  end

  // Output decode. Every strobe defaults low and only the owning state raises it.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    halted        = 1'b0;
    case (state_r)
      FETCH: begin
        // The IR and PC load only in the cycle the fetch completes, so the PC
        // advances exactly once per fetch.
        mem_read  = 1'b1;
        ir_write  = ready_s;
        pc_write  = ready_s;
        alu_src_b = 2'b01;
      end
      DECODE: begin
        // The branch target is precomputed into ALUOut in case this is a beq.
        alu_src_b = 2'b11;
      end
      MEM_ADDR, ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = ready_s;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control. Stall-specific scenarios
// follow the MC_CTRL_STALL_EN build option.
module tb_mips_mc_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, halted;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state_dbg;
  logic [17:0] ctrl_w;

  int checks;
  int failures;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .halted(halted), .state_dbg(state_dbg)
  );

  // Packing order: pw,pwc,ps[2],iod,mr,mw,irw,rd,m2r,rw,asa,asb[2],aop[2],done,halt
  assign ctrl_w = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                   alu_op, instr_done, halted};

  localparam logic [17:0] C_ZERO      = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [17:0] C_FETCH_RDY = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
  localparam logic [17:0] C_FETCH_WT  = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [17:0] C_DECODE    = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
  localparam logic [17:0] C_MEM_ADDR  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [17:0] C_MEM_RD    = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [17:0] C_MEM_WB    = 18'b0_0_00_0_0_0_0_0_1_1_0_00_00_1_0;
  localparam logic [17:0] C_MEM_WR    = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_1_0;
  localparam logic [17:0] C_MEM_WR_WT = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [17:0] C_EXEC      = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [17:0] C_R_WB      = 18'b0_0_00_0_0_0_0_1_0_1_0_00_00_1_0;
  localparam logic [17:0] C_ADDI_WB   = 18'b0_0_00_0_0_0_0_0_0_1_0_00_00_1_0;
  localparam logic [17:0] C_BRANCH    = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_1_0;
  localparam logic [17:0] C_JUMP      = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_1_0;
  localparam logic [17:0] C_HALT      = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Check the settled state and controls of the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] ctl);
    check({tag, "_state"}, {28'd0, state_dbg}, {28'd0, st});
    check({tag, "_ctrl"}, {14'd0, ctrl_w}, {14'd0, ctl});
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    opcode    = 6'b000000;
    zero_flag = 1'b0;
    mem_ready = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("rst_state", {28'd0, state_dbg}, 32'd0);
      check("rst_ctrl", {14'd0, ctrl_w}, {14'd0, C_ZERO});
    end
    rst = 1'b1;

    // lw; opcode is switched to sw during MEM_ADDR and must be ignored
    opcode = 6'b100011;
    cyc("boot", 4'd0, C_ZERO);
    cyc("lw_fetch", 4'd1, C_FETCH_RDY);
    cyc("lw_decode", 4'd2, C_DECODE);
    opcode = 6'b101011;
    cyc("lw_addr", 4'd3, C_MEM_ADDR);
    cyc("lw_rd", 4'd4, C_MEM_RD);
    cyc("lw_wb", 4'd5, C_MEM_WB);

    // sw
    cyc("sw_fetch", 4'd1, C_FETCH_RDY);
    cyc("sw_decode", 4'd2, C_DECODE);
    cyc("sw_addr", 4'd3, C_MEM_ADDR);
    cyc("sw_wr", 4'd6, C_MEM_WR);

    // R-type
    opcode = 6'b000000;
    cyc("r_fetch", 4'd1, C_FETCH_RDY);
    cyc("r_decode", 4'd2, C_DECODE);
    cyc("r_exec", 4'd7, C_EXEC);
    cyc("r_wb", 4'd8, C_R_WB);

    // addi
    opcode = 6'b001000;
    cyc("addi_fetch", 4'd1, C_FETCH_RDY);
    cyc("addi_decode", 4'd2, C_DECODE);
    cyc("addi_ex", 4'd11, C_MEM_ADDR);
    cyc("addi_wb", 4'd12, C_ADDI_WB);

    // beq taken
    opcode    = 6'b000100;
    zero_flag = 1'b1;
    cyc("beq_fetch", 4'd1, C_FETCH_RDY);
    cyc("beq_decode", 4'd2, C_DECODE);
    cyc("beq_branch", 4'd9, C_BRANCH);

    // j
    opcode    = 6'b000010;
    zero_flag = 1'b0;
    cyc("j_fetch", 4'd1, C_FETCH_RDY);
    cyc("j_decode", 4'd2, C_DECODE);
    cyc("j_jump", 4'd10, C_JUMP);

`ifdef MC_CTRL_STALL_EN
    // Fetch stall: three wait cycles, PC/IR load only on the ready cycle
    opcode    = 6'b100011;
    mem_ready = 1'b0;
    cyc("stall_f0", 4'd1, C_FETCH_WT);
    cyc("stall_f1", 4'd1, C_FETCH_WT);
    cyc("stall_f2", 4'd1, C_FETCH_WT);
    mem_ready = 1'b1;
    cyc("stall_f3", 4'd1, C_FETCH_RDY);
    cyc("stall_decode", 4'd2, C_DECODE);
    cyc("stall_addr", 4'd3, C_MEM_ADDR);
    mem_ready = 1'b0;
    cyc("stall_rd0", 4'd4, C_MEM_RD);
    mem_ready = 1'b1;
    cyc("stall_rd1", 4'd4, C_MEM_RD);
    cyc("stall_wb", 4'd5, C_MEM_WB);
`else
    // mem_ready has no effect in this build: no stall in FETCH or MEM_RD
    opcode    = 6'b100011;
    mem_ready = 1'b0;
    cyc("nostall_fetch", 4'd1, C_FETCH_RDY);
    cyc("nostall_decode", 4'd2, C_DECODE);
    cyc("nostall_addr", 4'd3, C_MEM_ADDR);
    cyc("nostall_rd", 4'd4, C_MEM_RD);
    cyc("nostall_wb", 4'd5, C_MEM_WB);
    mem_ready = 1'b1;
`endif

    // Illegal opcode traps and holds regardless of inputs
    opcode = 6'b111111;
    cyc("ill_fetch", 4'd1, C_FETCH_RDY);
    cyc("ill_decode", 4'd2, C_DECODE);
    for (int i = 0; i < 22; i++) begin
      opcode    = 6'($urandom_range(0, 63));
      mem_ready = 1'($urandom_range(0, 1));
      zero_flag = 1'($urandom_range(0, 1));
      cyc("halt_hold", 4'd13, C_HALT);
    end

    // Reset clears the trap asynchronously
    rst = 1'b0;
    #1;
    check("halt_rst_state", {28'd0, state_dbg}, 32'd0);
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    mem_ready = 1'b1;
    zero_flag = 1'b0;
    opcode    = 6'b101011;
    cyc("rs_boot", 4'd0, C_ZERO);
    cyc("rs_fetch", 4'd1, C_FETCH_RDY);
    cyc("rs_decode", 4'd2, C_DECODE);
    cyc("rs_addr", 4'd3, C_MEM_ADDR);

    // Reset pulsed in the middle of MEM_WR drops the write at once
`ifdef MC_CTRL_STALL_EN
    mem_ready = 1'b0;
    check("wr_pre_ctrl", {14'd0, ctrl_w}, {14'd0, C_MEM_WR_WT});
`else
    check("wr_pre_ctrl", {14'd0, ctrl_w}, {14'd0, C_MEM_WR});
`endif
    check("wr_pre_state", {28'd0, state_dbg}, 32'd6);
    rst = 1'b0;
    #1;
    check("wr_rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("wr_rst_state", {28'd0, state_dbg}, 32'd0);
    check("wr_rst_ctrl", {14'd0, ctrl_w}, {14'd0, C_ZERO});
    @(posedge clk);
    #2;
    check("wr_held_ctrl", {14'd0, ctrl_w}, {14'd0, C_ZERO});
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    cyc("re_boot", 4'd0, C_ZERO);
    cyc("re_fetch", 4'd1, C_FETCH_RDY);
    cyc("re_decode", 4'd2, C_DECODE);
    cyc("re_exec", 4'd7, C_EXEC);
    cyc("re_wb", 4'd8, C_R_WB);
    cyc("re_fetch2", 4'd1, C_FETCH_RDY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
